// File: rtl/weight_fetch_ctrl.sv
// Weight SRAM fetch controller: streams one layer's packed weight words from SRAM
// through a 2-entry skid FIFO to a valid/ready consumer.
module weight_fetch_ctrl #(
   parameter  int WEIGHT_PER_ADDR = 9,
   parameter  int BW_PER_PARAM    = 10,
   parameter  int ADDR_BW         = 7,
   localparam int WW              = WEIGHT_PER_ADDR * BW_PER_PARAM
) (
   input  logic               clk,
   input  logic               srstn,
   input  logic               start,
   input  logic [2:0]         layer_sel,
   input  logic               abort,
   output logic               sram_csb,
   output logic [ADDR_BW-1:0] sram_raddr,
   input  logic [WW-1:0]      sram_rdata,
   output logic               w_valid,
   input  logic               w_ready,
   output logic [WW-1:0]      w_data,
   output logic [5:0]         w_idx,
   output logic               w_last,
   output logic               busy,
   output logic               done
);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   // {base address, word count} for each layer
   function automatic logic [12:0] layer_map(input logic [2:0] sel);
      case (sel)
         3'd0:    layer_map = {7'd0,  6'd1};
         3'd1:    layer_map = {7'd1,  6'd9};
         3'd2:    layer_map = {7'd10, 6'd18};
         3'd3:    layer_map = {7'd28, 6'd9};
         3'd4:    layer_map = {7'd37, 6'd18};
         3'd5:    layer_map = {7'd55, 6'd9};
         3'd6:    layer_map = {7'd64, 6'd9};
         default: layer_map = {7'd73, 6'd36};
      endcase
   endfunction

   state_t             state_q, state_d;
   logic [ADDR_BW-1:0] addr_q;
   logic [5:0]         remain_q;
   logic [5:0]         issue_idx_q;
   logic               vld_p1;
   logic [5:0]         idx_p1;
   logic               last_p1;
   logic [WW-1:0]      data_mem [2];
   logic [5:0]         idx_mem  [2];
   logic               last_mem [2];
   logic               wr_ptr_q, rd_ptr_q;
   logic [1:0]         count_q;
   logic               issue, pop, accept;
   logic [2:0]         occ;
   logic [6:0]         sel_base;
   logic [5:0]         sel_words;

   assign {sel_base, sel_words} = layer_map(layer_sel);

   assign w_valid    = (count_q != 2'd0);
   assign pop        = w_valid & w_ready;
   assign w_data     = w_valid ? data_mem[rd_ptr_q] : '0;
   assign w_idx      = w_valid ? idx_mem[rd_ptr_q]  : '0;
   assign w_last     = w_valid & last_mem[rd_ptr_q];
   assign sram_raddr = addr_q;
   // FIFO occupancy once this cycle's returning read lands and the head leaves
   assign occ        = {1'b0, count_q} + {2'b0, vld_p1} - {2'b0, pop};
   // the cycle done pulses is still a closing cycle, so start is refused there
   assign accept     = (state_q == IDLE) & start & ~done & ~abort;

   always_ff @(posedge clk) begin
      if (!srstn) state_q <= IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (accept) state_d = FETCH;
         FETCH:   if (issue && remain_q == 6'd1) state_d = DRAIN;
         DRAIN:   if (pop && w_last) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      if (abort) state_d = IDLE;
   end

   always_comb begin
      issue    = (state_q == FETCH) && (occ < 3'd2);
      sram_csb = ~issue;
      busy     = (state_q != IDLE);
   end

   always_ff @(posedge clk) begin
      if (!srstn) begin
         addr_q      <= '0;
         remain_q    <= '0;
         issue_idx_q <= '0;
         vld_p1      <= 1'b0;
         wr_ptr_q    <= 1'b0;
         rd_ptr_q    <= 1'b0;
         count_q     <= '0;
         done        <= 1'b0;
      end else begin
         done <= pop & w_last & ~abort;
         if (abort) begin
            vld_p1   <= 1'b0;
            wr_ptr_q <= 1'b0;
            rd_ptr_q <= 1'b0;
            count_q  <= '0;
         end else begin
            vld_p1  <= issue;
            count_q <= count_q + {1'b0, vld_p1} - {1'b0, pop};
            if (vld_p1) wr_ptr_q <= ~wr_ptr_q;
            if (pop)    rd_ptr_q <= ~rd_ptr_q;
         end
         if (accept) begin
            addr_q      <= ADDR_BW'(sel_base);
            remain_q    <= sel_words;
            issue_idx_q <= '0;
         end else if (issue) begin
            remain_q    <= remain_q - 6'd1;
            issue_idx_q <= issue_idx_q + 6'd1;
            // the address stays on the last issued word once the layer is exhausted
            if (remain_q != 6'd1) addr_q <= addr_q + ADDR_BW'(1);
         end
      end
   end

   // ---- p1: read in flight, p2: word captured into FIFO ----
   always_ff @(posedge clk) begin
      if (issue) begin
         idx_p1  <= issue_idx_q;
         last_p1 <= (remain_q == 6'd1);
      end
      if (vld_p1) begin
         data_mem[wr_ptr_q] <= sram_rdata;
         idx_mem[wr_ptr_q]  <= idx_p1;
         last_mem[wr_ptr_q] <= last_p1;
      end
   end

endmodule

// File: tb/tb_weight_fetch_ctrl.sv
// Bench for weight_fetch_ctrl: SRAM model, layer-level reference model and
// directed plus randomized streaming scenarios.
module tb_weight_fetch_ctrl;

   typedef struct {
      logic [89:0] data;
      int          idx;
      bit          last;
   } word_t;

   logic        clk = 1'b0;
   logic        srstn, start, abort, w_ready;
   logic [2:0]  layer_sel;
   logic        sram_csb;
   logic [6:0]  sram_raddr;
   logic [89:0] sram_rdata;
   logic        w_valid, w_last, busy, done;
   logic [89:0] w_data;
   logic [5:0]  w_idx;

   int          errors = 0;
   int          checks = 0;
   logic [89:0] sram_mem [128];
   int          lbase  [8] = '{0, 1, 10, 28, 37, 55, 64, 73};
   int          lwords [8] = '{1, 9, 18, 9, 18, 9, 9, 36};

   word_t       exp_q[$];
   int          exp_addr[$];
   bit          mon_en = 1'b0;
   bit          m_busy = 1'b0, m_done = 1'b0;
   int          m_xfer_cnt = 0, m_layer = 0, out_cnt = 0;
   bit          k, x, lx, acc, iss;
   word_t       head;
   int          mode = 0, cyc = 0;

   weight_fetch_ctrl dut (
      .clk(clk), .srstn(srstn), .start(start), .layer_sel(layer_sel), .abort(abort),
      .sram_csb(sram_csb), .sram_raddr(sram_raddr), .sram_rdata(sram_rdata),
      .w_valid(w_valid), .w_ready(w_ready), .w_data(w_data), .w_idx(w_idx),
      .w_last(w_last), .busy(busy), .done(done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (sram_csb === 1'b0) sram_rdata <= sram_mem[sram_raddr];
   end

   task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Reference model: layer-level view of which reads and words must appear
   always @(negedge clk) begin
      if (mon_en) begin
         k   = abort || !srstn;
         iss = (sram_csb === 1'b0);
         x   = 1'b0;
         lx  = 1'b0;
         check("busy", 128'(busy), 128'(m_busy));
         check("done", 128'(done), 128'(m_done));
         if (iss && !k) begin
            check("issue_expected", 128'(exp_addr.size() != 0), 128'(1));
            if (exp_addr.size() != 0) check("raddr", 128'(sram_raddr), 128'(exp_addr.pop_front()));
         end
         if (w_valid !== 1'b0 && !k) begin
            check("word_expected", 128'(exp_q.size() != 0), 128'(1));
            if (exp_q.size() != 0) begin
               head = exp_q[0];
               check("w_data", 128'(w_data), 128'(head.data));
               check("w_idx",  128'(w_idx),  128'(head.idx));
               check("w_last", 128'(w_last), 128'(head.last));
               if (w_ready) begin
                  x  = 1'b1;
                  lx = head.last;
                  void'(exp_q.pop_front());
                  m_xfer_cnt++;
               end
            end
         end
         acc = start && !m_busy && !m_done && !k;
         if (k) begin
            exp_q.delete();
            exp_addr.delete();
            m_busy  = 1'b0;
            m_done  = 1'b0;
            out_cnt = 0;
         end else begin
            out_cnt = out_cnt + int'(iss) - int'(x);
            if (iss) check("outstanding_le2", 128'(out_cnt <= 2), 128'(1));
            if (acc) begin
               m_layer    = int'(layer_sel);
               m_xfer_cnt = 0;
               for (int i = 0; i < lwords[layer_sel]; i++) begin
                  word_t w;
                  w.data = sram_mem[lbase[layer_sel] + i];
                  w.idx  = i;
                  w.last = (i == lwords[layer_sel] - 1);
                  exp_addr.push_back(lbase[layer_sel] + i);
                  exp_q.push_back(w);
               end
            end
            m_done = lx;
            if (acc)     m_busy = 1'b1;
            else if (lx) m_busy = 1'b0;
         end
      end
   end

   task automatic step();
      case (mode)
         0:       w_ready = 1'b1;
         1:       w_ready = 1'($urandom_range(0, 1));
         2:       w_ready = (cyc >= 8 && cyc < 13) ? 1'b0 : (cyc % 2 == 0);
         default: w_ready = 1'b0;
      endcase
      cyc++;
      @(posedge clk);
      #1;
   endtask

   task automatic do_start(input int sel);
      start     = 1'b1;
      layer_sel = 3'(sel);
      step();
      start     = 1'b0;
   endtask

   task automatic run_idle();
      int n = 0;
      while ((m_busy || m_done || exp_q.size() != 0) && n < 400) begin
         step();
         n++;
      end
      check("drain_in_budget", 128'(n < 400), 128'(1));
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, "_csb"},    128'(sram_csb),   128'(1));
      check({tag, "_raddr"},  128'(sram_raddr), 128'(0));
      check({tag, "_wvalid"}, 128'(w_valid),    128'(0));
      check({tag, "_wdata"},  128'(w_data),     128'(0));
      check({tag, "_widx"},   128'(w_idx),      128'(0));
      check({tag, "_wlast"},  128'(w_last),     128'(0));
      check({tag, "_busy"},   128'(busy),       128'(0));
      check({tag, "_done"},   128'(done),       128'(0));
   endtask

   initial begin
      logic [95:0] r;
      srstn = 1'b0; start = 1'b0; abort = 1'b0; w_ready = 1'b0; layer_sel = 3'd0;
      for (int a = 0; a < 128; a++) begin
         r = {$urandom, $urandom, $urandom};
         sram_mem[a] = r[89:0];
      end
      sram_rdata = '0;
      repeat (3) step();
      check_reset_outputs("rst");
      srstn  = 1'b1;
      mon_en = 1'b1;
      step();

      // conv1: single word, latency and done timing, start in done cycle refused
      mode = 0;
      do_start(0);
      check("l0_csb_n1",   128'(sram_csb),   128'(0));
      check("l0_raddr",    128'(sram_raddr), 128'(0));
      check("l0_busy",     128'(busy),       128'(1));
      step();
      check("l0_nvalid_n1", 128'(w_valid), 128'(0));
      step();
      check("l0_valid_n2", 128'(w_valid), 128'(1));
      check("l0_idx",      128'(w_idx),   128'(0));
      check("l0_last",     128'(w_last),  128'(1));
      step();
      check("l0_done_n3",  128'(done),    128'(1));
      check("l0_busy_n3",  128'(busy),    128'(0));
      start = 1'b1; layer_sel = 3'd2;
      step();
      check("start_in_done_ignored", 128'(busy), 128'(0));
      layer_sel = 3'd0;
      step();
      check("start_after_done_taken", 128'(busy), 128'(1));
      start = 1'b0;
      run_idle();

      // conv5: back-to-back issue of 36 addresses
      do_start(7);
      for (int i = 0; i < 36; i++) begin
         check("l7_issue_each_cycle", 128'(sram_csb), 128'(0));
         step();
      end
      check("l7_issue_stops", 128'(sram_csb), 128'(1));
      run_idle();
      check("l7_words", 128'(m_xfer_cnt), 128'(36));
      check("raddr_hold_idle", 128'(sram_raddr), 128'(108));

      // conv3_1 under toggling backpressure and a stall stretch
      mode = 2; cyc = 0;
      do_start(2);
      run_idle();
      check("l2_words", 128'(m_xfer_cnt), 128'(18));
      mode = 0;

      // start while busy is ignored
      do_start(4);
      repeat (4) step();
      start = 1'b1; layer_sel = 3'd1;
      step();
      start = 1'b0;
      run_idle();
      check("l4_words", 128'(m_xfer_cnt), 128'(18));
      check("l4_layer", 128'(m_layer),    128'(4));

      // abort on the 5th word of conv4 with the FIFO full
      do_start(6);
      for (int n = 0; n < 50 && m_xfer_cnt < 4; n++) step();
      check("l6_reached_5th", 128'(m_xfer_cnt), 128'(4));
      mode = 3;
      repeat (3) step();
      check("l6_stalled_valid", 128'(w_valid), 128'(1));
      check("l6_stalled_idx",   128'(w_idx),   128'(4));
      mode = 0; abort = 1'b1;
      step();
      abort = 1'b0;
      check("abort_wvalid", 128'(w_valid),  128'(0));
      check("abort_busy",   128'(busy),     128'(0));
      check("abort_done",   128'(done),     128'(0));
      check("abort_csb",    128'(sram_csb), 128'(1));
      step();
      check("abort_no_done", 128'(done),    128'(0));
      check("abort_quiet",   128'(w_valid), 128'(0));
      do_start(3);
      run_idle();
      check("l3_words", 128'(m_xfer_cnt), 128'(9));

      // reset mid conv4_2
      mode = 1;
      do_start(5);
      repeat (6) step();
      srstn = 1'b0;
      step();
      srstn = 1'b1;
      check_reset_outputs("midrst");
      repeat (10) step();
      check("midrst_no_valid", 128'(w_valid), 128'(0));
      do_start(5);
      run_idle();
      check("l5_words", 128'(m_xfer_cnt), 128'(9));

      // random layers under random backpressure
      repeat (8) begin
         int sel;
         sel = int'($urandom_range(0, 7));
         repeat ($urandom_range(0, 3)) step();
         do_start(sel);
         run_idle();
         check("rand_words", 128'(m_xfer_cnt), 128'(lwords[sel]));
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL global_timeout: observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/weight_fetch_ctrl.md
WEIGHT_FETCH_CTRL -- requirements
Module: weight_fetch_ctrl

Interface
REQ-001 Parameter WEIGHT_PER_ADDR, default 9: weights packed per SRAM word.
REQ-002 Parameter BW_PER_PARAM, default 10: bits per weight; word width WW = WEIGHT_PER_ADDR*BW_PER_PARAM = 90.
REQ-003 Parameter ADDR_BW, default 7: weight SRAM address width.
REQ-004 clk  in  1  single clock; all state updates on its rising edge.
REQ-005 srstn  in  1  reset, synchronous, active-low.
REQ-006 start  in  1  one-cycle request to fetch one layer; sampled only in IDLE.
REQ-007 layer_sel  in  3  layer selector, sampled with start.
REQ-008 abort  in  1  synchronous cancel of the current fetch.
REQ-009 sram_csb  out  1  weight SRAM chip enable, active-low; low means read issued this cycle.
REQ-010 sram_raddr  out  ADDR_BW  weight SRAM read address.
REQ-011 sram_rdata  in  WW  SRAM read data, valid in the cycle after the issuing cycle.
REQ-012 w_valid  out  1  output word available.
REQ-013 w_ready  in  1  consumer accepts the word; transfer = w_valid & w_ready.
REQ-014 w_data  out  WW  packed weight word, unmodified from SRAM.
REQ-015 w_idx  out  6  word index within the layer, 0-based.
REQ-016 w_last  out  1  high with the layer's final word.
REQ-017 busy  out  1  high from the cycle after start is accepted until done.
REQ-018 done  out  1  one-cycle pulse after the last word transfers.

Function
REQ-019 Layer map (base, words) SHALL be fixed: 0:(0,1) conv1, 1:(1,9) conv2, 2:(10,18) conv3_1, 3:(28,9) conv3, 4:(37,18) conv4_1, 5:(55,9) conv4_2, 6:(64,9) conv4, 7:(73,36) conv5.
REQ-020 FSM states SHALL be IDLE, FETCH, DRAIN: IDLE->FETCH on start; FETCH->DRAIN when the last read issues; DRAIN->IDLE when the last word transfers; any state->IDLE on abort.
REQ-021 Reads SHALL issue in ascending order base..base+words-1, one address per issuing cycle; sram_csb is high in every non-issuing cycle.
REQ-022 A 2-entry output FIFO SHALL absorb SRAM latency; the controller issues only when fifo_count + inflight - (w_valid & w_ready) < 2, so the FIFO never overflows and no read data is ever lost.
REQ-023 With w_ready held high the block SHALL sustain one word per cycle after the first word.
REQ-024 Latency: start sampled at edge N -> first read issued in cycle N..N+1 -> word pushed at edge N+2 -> w_valid high after edge N+2.
REQ-025 w_data, w_idx and w_last SHALL hold stable while w_valid=1 and w_ready=0.
REQ-026 w_last SHALL be high on exactly one word per layer, and on the only word for conv1.
REQ-027 done SHALL pulse in the cycle after the w_last transfer; busy falls in the same cycle; a start in that cycle is ignored, and a start one cycle later is accepted.
REQ-028 start while busy SHALL be ignored, with no effect on address, count or layer.
REQ-029 abort SHALL, at the next edge, empty the FIFO, discard any in-flight read, deassert w_valid, set sram_csb=1 and return to IDLE without a done pulse; abort has priority over start and over a simultaneous transfer.
REQ-030 sram_raddr SHALL hold its last issued value while idle.

Reset
REQ-031 While srstn=0 at a clock edge, the block SHALL enter IDLE with sram_csb=1, sram_raddr=0, w_valid=0, w_data=0, w_idx=0, w_last=0, busy=0, done=0, FIFO empty and no read in flight.
REQ-032 Reset asserted mid-fetch SHALL behave as abort, with no done pulse and no stale word presented after release.

Verification
REQ-033 layer_sel=0, w_ready=1 -> one read at addr 0; w_valid at N+2 with w_idx=0 and w_last=1; done at N+3.
REQ-034 layer_sel=7, w_ready=1 -> addresses 73..108 issue on consecutive cycles; 36 words in order with w_idx 0..35; w_last only on idx 35.
REQ-035 layer_sel=2, w_ready toggling 1010... plus a 5-cycle low stretch -> 18 words (addr 10..27) with none lost or duplicated; outputs stable while stalled; never more than 2 reads outstanding.
REQ-036 start during layer 4 fetch with layer_sel=1 -> ignored; layer 4 completes with 18 words from 37..54.
REQ-037 abort on the 5th word of layer 6 with FIFO full -> next cycle w_valid=0, busy=0, no done; a following start with layer_sel=3 delivers addr 28..36 cleanly.
REQ-038 srstn=0 for 1 cycle mid-layer-5 -> all outputs at reset values; no w_valid until a new start.
